// File: rtl/render_pkg.sv
// render_pkg: types and helpers shared by the render back end.
// Holds the depth-test FSM state type, the default geometry of the tile
// depth buffer and the nearer-than depth compare used by depth_test_unit.
package render_pkg;

    // Depth test unit frame phases
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        TEST,
        DRAIN,
        DONE
    } depth_state_t;

    localparam int   DEFAULT_DEPTH_WIDTH   = 16;
    localparam int   DEFAULT_FB_ADDR_WIDTH = 4;

    // Clear fills every bit with this value, giving the farthest depth
    localparam logic CLEAR_FILL_BIT = 1'b1;

    // Smaller depth is nearer; equal depth does not win
    function automatic logic depth_nearer(input logic [31:0] frag_depth,
                                          input logic [31:0] stored_depth);
        return frag_depth < stored_depth;
    endfunction

endpackage

// File: rtl/depth_test_unit_if.sv
// depth_test_unit_if: fragment stream in, pixel strobe and status out.
// master = rasterizer side / frame controller, slave = depth_test_unit.
interface depth_test_unit_if #(
    parameter int DEPTH_WIDTH   = 16,
    parameter int FB_ADDR_WIDTH = 4
) ();

    logic                     clear_start;
    logic                     frag_valid;
    logic [FB_ADDR_WIDTH-1:0] frag_addr;
    logic [DEPTH_WIDTH-1:0]   frag_depth;
    logic                     raster_done;
    logic                     ready;
    logic                     pixel_we;
    logic [FB_ADDR_WIDTH-1:0] pixel_addr;
    logic                     done;
    logic                     overrun;

    modport master (
        output clear_start, frag_valid, frag_addr, frag_depth, raster_done,
        input  ready, pixel_we, pixel_addr, done, overrun
    );

    modport slave (
        input  clear_start, frag_valid, frag_addr, frag_depth, raster_done,
        output ready, pixel_we, pixel_addr, done, overrun
    );

endinterface

// File: rtl/depth_buffer_ram.sv
// depth_buffer_ram: 1R1W synchronous tile depth buffer, single clock.
// Read-first: a read and write to the same address in one cycle returns
// the old contents; the caller forwards the new value where it matters.
module depth_buffer_ram #(
    parameter int DEPTH_WIDTH = 16,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [ADDR_WIDTH-1:0]  waddr_i,
    input  logic [DEPTH_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0]  raddr_i,
    output logic [DEPTH_WIDTH-1:0] rdata_o
);

    localparam int ENTRIES = 2 ** ADDR_WIDTH;

    logic [DEPTH_WIDTH-1:0] mem_q [ENTRIES];
    logic [DEPTH_WIDTH-1:0] rdata_q;

    // Registered read of the pre-write contents, plus the optional write
    // NOTE: the array has no reset so it maps onto RAM macros; the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/depth_test_unit.sv
// depth_test_unit: per-fragment depth test behind the rasterizer.
// Clears the tile depth buffer at frame start, then tests each fragment
// (read in cycle N, compare and write in N+1, pixel strobe visible in N+2)
// with a one-entry forward register covering back-to-back same-address hits.
// Optional feature: define DEPTH_TEST_STATS_EN to add saturating
// pass_count / fail_count outputs.
module depth_test_unit
    import render_pkg::*;
#(
    parameter int                     DEPTH_WIDTH   = DEFAULT_DEPTH_WIDTH,
    parameter int                     FB_ADDR_WIDTH = DEFAULT_FB_ADDR_WIDTH,
    parameter logic [DEPTH_WIDTH-1:0] CLEAR_DEPTH   = {DEPTH_WIDTH{CLEAR_FILL_BIT}}
) (
    input  logic                clk,
    input  logic                rst,
    depth_test_unit_if.slave    bus
`ifdef DEPTH_TEST_STATS_EN
    ,
    output logic [31:0]         pass_count,
    output logic [31:0]         fail_count
`endif
);

    localparam int                     FB_SIZE   = 2 ** FB_ADDR_WIDTH;
    localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR = FB_ADDR_WIDTH'(FB_SIZE - 1);

    // Frame control
    depth_state_t             state_q;
    logic                     ready_q;
    logic                     done_q;
    logic                     drain_cnt_q;
    logic [FB_ADDR_WIDTH-1:0] clr_addr_q;
    logic                     overrun_q;
    logic                     accept_clear_d;

    // Compare stage (fragment accepted one cycle earlier)
    logic                     s1_valid_q;
    logic [FB_ADDR_WIDTH-1:0] s1_addr_q;
    logic [DEPTH_WIDTH-1:0]   s1_depth_q;

    // Last depth written by a passing fragment
    logic                     fwd_valid_q;
    logic [FB_ADDR_WIDTH-1:0] fwd_addr_q;
    logic [DEPTH_WIDTH-1:0]   fwd_depth_q;

    // Output stage
    logic                     pixel_we_q;
    logic [FB_ADDR_WIDTH-1:0] pixel_addr_q;

    // Combinational compare / RAM port
    logic                     clearing_d;
    logic                     fwd_hit_d;
    logic [DEPTH_WIDTH-1:0]   stored_d;
    logic                     pass_d;
    logic                     ram_we_d;
    logic [FB_ADDR_WIDTH-1:0] ram_waddr_d;
    logic [DEPTH_WIDTH-1:0]   ram_wdata_d;
    logic [DEPTH_WIDTH-1:0]   ram_rdata;

    assign accept_clear_d = bus.clear_start && ((state_q == IDLE) || (state_q == DONE));

    // Frame FSM: clear sweep, fragment test, two-cycle drain, done hold
    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            drain_cnt_q <= 1'b0;
            clr_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept_clear_d) begin
                        state_q    <= CLEAR;
                        done_q     <= 1'b0;
                        clr_addr_q <= '0;
                    end
                end
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q <= TEST;
                        ready_q <= 1'b1;
                    end
                end
                TEST: begin
                    if (bus.raster_done) begin
                        state_q     <= DRAIN;
                        ready_q     <= 1'b0;
                        drain_cnt_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    drain_cnt_q <= 1'b1;
                    if (drain_cnt_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag for fragments arriving while not in TEST
    always_ff @(posedge clk) begin
        if (rst || accept_clear_d) begin
            overrun_q <= 1'b0;
        end else if (bus.frag_valid && !ready_q) begin
            overrun_q <= 1'b1;
        end
    end

    // Stage 1: capture accepted fragment while its RAM read is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= bus.frag_valid && ready_q;
        end
        s1_addr_q  <= bus.frag_addr;
        s1_depth_q <= bus.frag_depth;
    end

    // Depth compare and RAM write port arbitration (clear sweep or passing fragment)
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        clearing_d  = (state_q == CLEAR);
        fwd_hit_d   = 1'b0;
        stored_d    = ram_rdata;
        pass_d      = 1'b0;
        ram_we_d    = 1'b0;
        ram_waddr_d = s1_addr_q;
        ram_wdata_d = s1_depth_q;

        if (fwd_valid_q && (fwd_addr_q == s1_addr_q)) begin
            fwd_hit_d = 1'b1;
            stored_d  = fwd_depth_q;
        end

        pass_d = s1_valid_q && depth_nearer(32'(s1_depth_q), 32'(stored_d));

        if (clearing_d) begin
            ram_waddr_d = clr_addr_q;
            ram_wdata_d = CLEAR_DEPTH;
        end
        // A reset edge must not commit a write from the aborted frame
        ram_we_d = !rst && (clearing_d || pass_d);
    end

    // Forward register: holds the most recent passing write
    always_ff @(posedge clk) begin
        if (rst || clearing_d) begin
            fwd_valid_q <= 1'b0;
        end else if (pass_d) begin
            fwd_valid_q <= 1'b1;
        end
        if (pass_d) begin
            fwd_addr_q  <= s1_addr_q;
            fwd_depth_q <= s1_depth_q;
        end
    end

    // Registered pixel strobe and address
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_we_q   <= 1'b0;
            pixel_addr_q <= '0;
        end else begin
            pixel_we_q <= pass_d;
            if (pass_d) begin
                pixel_addr_q <= s1_addr_q;
            end
        end
    end

    depth_buffer_ram #(
        .DEPTH_WIDTH (DEPTH_WIDTH),
        .ADDR_WIDTH  (FB_ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_d),
        .waddr_i (ram_waddr_d),
        .wdata_i (ram_wdata_d),
        .raddr_i (bus.frag_addr),
        .rdata_o (ram_rdata)
    );

`ifdef DEPTH_TEST_STATS_EN
    logic [31:0] pass_count_q;
    logic [31:0] fail_count_q;

    // Saturating pass/fail counters, restarted with each frame's clear
    always_ff @(posedge clk) begin
        if (rst || accept_clear_d) begin
            pass_count_q <= '0;
            fail_count_q <= '0;
        end else if (s1_valid_q) begin
            if (pass_d && (pass_count_q != '1)) begin
                pass_count_q <= pass_count_q + 1'b1;
            end
            if (!pass_d && (fail_count_q != '1)) begin
                fail_count_q <= fail_count_q + 1'b1;
            end
        end
    end

    assign pass_count = pass_count_q;
    assign fail_count = fail_count_q;
`else
    // Statistics counters not built
`endif

    assign bus.ready      = ready_q;
    assign bus.pixel_we   = pixel_we_q;
    assign bus.pixel_addr = pixel_addr_q;
    assign bus.done       = done_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_depth_test_unit.sv
// tb_depth_test_unit: self-checking bench for depth_test_unit.
// Directed table of fragments plus multi-cycle sequences (clear timing,
// overrun, drain/done, reset mid-clear) and a randomized phase checked
// against a per-address nearest-depth model.
module tb_depth_test_unit;

    localparam int DW      = 16;
    localparam int AW      = 4;
    localparam int FB_SIZE = 2 ** AW;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    depth_test_unit_if #(.DEPTH_WIDTH(DW), .FB_ADDR_WIDTH(AW)) bus ();

`ifdef DEPTH_TEST_STATS_EN
    logic [31:0] pass_count;
    logic [31:0] fail_count;
`endif

    depth_test_unit #(
        .DEPTH_WIDTH   (DW),
        .FB_ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef DEPTH_TEST_STATS_EN
        ,
        .pass_count (pass_count),
        .fail_count (fail_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          exp_we;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frag(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.frag_valid = v;
        bus.frag_addr  = a;
        bus.frag_depth = d;
    endtask

    // Start a clear and count cycles until ready; optionally inject a
    // fragment frag_at cycles into the sweep (must be dropped).
    task automatic do_clear(input int frag_at);
        int n;
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        check("clear_done_low", bus.done, 1'b0);
        check("clear_overrun_reset", bus.overrun, 1'b0);
        n = 0;
        while (!bus.ready && n < 40) begin
            drive_frag(n == frag_at, 4'd3, 16'd0);
            step();
            check("clear_no_pixel", bus.pixel_we, 1'b0);
            n++;
        end
        drive_frag(1'b0, '0, '0);
        check("clear_cycles", n, FB_SIZE);
        if (frag_at >= 0) check("overrun_set", bus.overrun, 1'b1);
    endtask

    // raster_done (optionally with a same-cycle fragment) -> DRAIN -> DONE
    task automatic finish_frame(input logic with_frag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive_frag(with_frag, a, d);
        bus.raster_done = 1'b1;
        step();
        drive_frag(1'b0, '0, '0);
        check("drain_ready_low", bus.ready, 1'b0);
        check("drain_done_low0", bus.done, 1'b0);
        step();
        check("last_pixel_we", bus.pixel_we, with_frag);
        if (with_frag) check("last_pixel_addr", bus.pixel_addr, a);
        check("drain_done_low1", bus.done, 1'b0);
        step();
        check("done_high", bus.done, 1'b1);
        check("done_no_pixel", bus.pixel_we, 1'b0);
        bus.raster_done = 1'b0;
        step();
        step();
        check("done_held", bus.done, 1'b1);
    endtask

    logic [DW-1:0] model_mem [FB_SIZE];

    initial begin
        logic          prev_we;
        logic [AW-1:0] prev_addr;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.clear_start = 1'b0;
        bus.raster_done = 1'b0;
        drive_frag(1'b0, '0, '0);

        vecs[0]  = '{1'b1, 4'd3,  16'd100,   1'b1};
        vecs[1]  = '{1'b1, 4'd3,  16'd200,   1'b0};
        vecs[2]  = '{1'b1, 4'd3,  16'd100,   1'b0};
        vecs[3]  = '{1'b0, 4'd0,  16'd0,     1'b0};
        vecs[4]  = '{1'b1, 4'd5,  16'd100,   1'b1};
        vecs[5]  = '{1'b1, 4'd5,  16'd50,    1'b1};
        vecs[6]  = '{1'b1, 4'd6,  16'd50,    1'b1};
        vecs[7]  = '{1'b1, 4'd6,  16'd100,   1'b0};
        vecs[8]  = '{1'b1, 4'd7,  16'd50,    1'b1};
        vecs[9]  = '{1'b0, 4'd0,  16'd0,     1'b0};
        vecs[10] = '{1'b1, 4'd7,  16'd60,    1'b0};
        vecs[11] = '{1'b1, 4'd9,  16'hFFFF,  1'b0};
        vecs[12] = '{1'b1, 4'd12, 16'hFFFE,  1'b1};
        vecs[13] = '{1'b1, 4'd12, 16'hFFFE,  1'b0};

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_ready", bus.ready, 1'b0);
        check("rst_pixel_we", bus.pixel_we, 1'b0);
        check("rst_pixel_addr", bus.pixel_addr, '0);
        check("rst_done", bus.done, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);

        // Clear with a fragment dropped during the sweep
        do_clear(3);

        // Directed fragment table: result of vector i appears after vector i+1's edge
        prev_we   = 1'b0;
        prev_addr = '0;
        for (int i = 0; i < 14; i++) begin
            drive_frag(vecs[i].v, vecs[i].a, vecs[i].d);
            step();
            check("tbl_ready", bus.ready, 1'b1);
            check($sformatf("tbl_we[%0d]", i - 1), bus.pixel_we, prev_we);
            if (prev_we) check($sformatf("tbl_addr[%0d]", i - 1), bus.pixel_addr, prev_addr);
            prev_we   = vecs[i].exp_we;
            prev_addr = vecs[i].a;
        end
        drive_frag(1'b0, '0, '0);
        step();
        check("tbl_we[13]", bus.pixel_we, prev_we);
        check("overrun_sticky", bus.overrun, 1'b1);

        // Last fragment arrives together with raster_done
        finish_frame(1'b1, 4'd10, 16'd5);

        // New frame: clear must reset overrun and restore farthest depth everywhere
        do_clear(-1);
        for (int i = 0; i < FB_SIZE; i++) model_mem[i] = '1;

        prev_we   = 1'b0;
        prev_addr = '0;
        for (int c = 0; c < 400; c++) begin
            logic          v;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic          cur_we;
            v = ($urandom_range(0, 3) != 0);
            a = AW'($urandom_range(0, FB_SIZE - 1));
            d = ($urandom_range(0, 7) == 0) ? 16'hFFFF : DW'($urandom_range(0, 4000));
            // clear_start during TEST must be ignored
            bus.clear_start = ($urandom_range(0, 15) == 0);
            cur_we = v && (d < model_mem[a]);
            if (cur_we) model_mem[a] = d;
            drive_frag(v, a, d);
            step();
            check("rand_ready", bus.ready, 1'b1);
            check("rand_we", bus.pixel_we, prev_we);
            if (prev_we) check("rand_addr", bus.pixel_addr, prev_addr);
            prev_we   = cur_we;
            prev_addr = a;
        end
        bus.clear_start = 1'b0;
        drive_frag(1'b0, '0, '0);
        step();
        check("rand_we_last", bus.pixel_we, prev_we);
        check("rand_overrun", bus.overrun, 1'b0);

        finish_frame(1'b0, '0, '0);

        // Reset while the sweep is writing address 4
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midclr_ready", bus.ready, 1'b0);
        check("midclr_done", bus.done, 1'b0);
        step();
        check("midclr_idle", bus.ready, 1'b0);

        do_clear(-1);
        drive_frag(1'b1, 4'd2, 16'd7);
        step();
        drive_frag(1'b0, '0, '0);
        step();
        check("post_rst_we", bus.pixel_we, 1'b1);
        check("post_rst_addr", bus.pixel_addr, 4'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
